// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: held byte, valid/ready handshake
// and the one-clock error pulses.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling on the baud generator's tick, mid-bit sampling,
// optional parity, stop-bit check and a one-entry valid/ready holding register.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      tick_16x,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic             ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bad_q, par_bad_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_err_q, overrun_err_d;
    logic                 rx_meta, rx_s;

    // Synchroniser resets to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            par_bad_q     <= 1'b0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            par_bad_q     <= par_bad_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            frame_err_q   <= frame_err_d;
            parity_err_q  <= parity_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        par_bad_d     = par_bad_q;
        data_d        = data_q;
        valid_d       = valid_q;
        frame_err_d   = 1'b0;
        parity_err_d  = 1'b0;
        overrun_err_d = 1'b0;

        // An accept is applied before a frame resolves, so a same-clock accept frees the slot.
        if (valid_q && bus.rx_ready) valid_d = 1'b0;

        if (tick_16x) begin
            cnt_d = cnt_q + 4'd1;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (!rx_s) state_d = ST_START;
                end
                ST_START: begin
                    if (cnt_q == 4'd7) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        par_bad_d = 1'b0;
                        state_d   = rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == 4'd15) begin
                        shreg_d[bit_idx_q] = rx_s;
                        if (bit_idx_q == LAST_IDX)
                            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        else
                            bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (cnt_q == 4'd15) begin
                        par_bad_d = ((^shreg_q) ^ rx_s) != ODD;
                        state_d   = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == 4'd15) begin
                        if (!rx_s) begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end else begin
                            state_d = ST_IDLE;
                            if (par_bad_q) begin
                                parity_err_d = 1'b1;
                            end else if (!valid_d) begin
                                data_d  = shreg_q;
                                valid_d = 1'b1;
                            end else begin
                                overrun_err_d = 1'b1;
                            end
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_s) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.rx_data     = data_q;
    assign bus.rx_valid    = valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.parity_err  = parity_err_q;
    assign bus.overrun_err = overrun_err_q;
endmodule
